t_switch_node: RTL

//  Registered, parametrised BFT T-switch: 3 ports (left, right, up), bufferless deflection routing.

---
 rtl/t_switch_node.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/t_switch_node.sv
// Registered 3-port BFT T-switch with bufferless deflection routing and per-input deflection counters.
// Optional T_SWAP_DEFLECT_EN: crossing side packets swap sides while a valid parent packet deflects up.
`timescale 1ns/1ps
module t_switch_node #(
    parameter int unsigned P_W    = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEVEL  = 1,
    parameter int unsigned POS    = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [P_W-1:0]   l_bus_i,
    input  logic [P_W-1:0]   r_bus_i,
    input  logic [P_W-1:0]   u_bus_i,
    output logic [P_W-1:0]   l_bus_o,
    output logic [P_W-1:0]   r_bus_o,
    output logic [P_W-1:0]   u_bus_o,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] defl_cnt_l,
    output logic [CNT_W-1:0] defl_cnt_r,
    output logic [CNT_W-1:0] defl_cnt_u
);
    localparam bit IsRoot = (LEVEL == ADDR_W - 1);

    typedef enum logic [1:0] {
        DirVoid  = 2'b00,
        DirLeft  = 2'b01,
        DirRight = 2'b10,
        DirUp    = 2'b11
    } dir_e;

    function automatic dir_e decode(input logic [P_W-1:0] pkt);
        logic [ADDR_W-1:0] addr;
        addr = pkt[P_W-2 -: ADDR_W];
        if (!pkt[P_W-1]) return DirVoid;
        if (!IsRoot && ((addr >> (LEVEL + 1)) != ADDR_W'(POS))) return DirUp;
        return addr[LEVEL] ? DirRight : DirLeft;
    endfunction

    dir_e             want_l, want_r, want_u;
    dir_e             got_l, got_r, got_u;
    logic [3:0]       free;  // indexed by dir_e; bit 0 (void) is never free
    logic             pend_l, pend_r, swap;
    logic             rr_q, rr_d;
    logic [P_W-1:0]   l_d, r_d, u_d, l_q, r_q, u_q;
    logic             defl_l, defl_r, defl_u;
    logic [CNT_W-1:0] cnt_l_q, cnt_r_q, cnt_u_q;

    always_comb begin
        want_l = decode(l_bus_i);
        want_r = decode(r_bus_i);
        want_u = IsRoot ? DirVoid : decode(u_bus_i);
        got_l  = DirVoid;
        got_r  = DirVoid;
        got_u  = DirVoid;
        free   = {!IsRoot, 1'b1, 1'b1, 1'b0};
        pend_l = 1'b0;
        pend_r = 1'b0;
        rr_d   = rr_q;
        swap   = 1'b0;
`ifdef T_SWAP_DEFLECT_EN
        swap = (want_l == DirRight) && (want_r == DirLeft) && (want_u != DirVoid);
`endif
        if (swap) begin
            got_l = DirRight;
            got_r = DirLeft;
            got_u = DirUp;
        end else begin
            // Turnback traffic always keeps its own port.
            if (want_l == DirLeft) begin got_l = DirLeft; free[DirLeft] = 1'b0; end
            if (want_r == DirRight) begin got_r = DirRight; free[DirRight] = 1'b0; end
            if (want_u == DirUp) begin got_u = DirUp; free[DirUp] = 1'b0; end
            if (want_u == DirLeft || want_u == DirRight) begin
                got_u = free[want_u] ? want_u : DirUp;
                free[got_u] = 1'b0;
            end
            pend_l = (want_l != DirVoid) && (got_l == DirVoid);
            pend_r = (want_r != DirVoid) && (got_r == DirVoid);
            if (pend_l && pend_r && (want_l == want_r) && free[want_l]) begin
                if (!rr_q) got_l = want_l;
                else       got_r = want_r;
                free[want_l] = 1'b0;
                rr_d = !rr_q;
            end else begin
                if (pend_l && free[want_l]) begin got_l = want_l; free[want_l] = 1'b0; end
                if (pend_r && free[want_r]) begin got_r = want_r; free[want_r] = 1'b0; end
            end
            if (pend_l && got_l == DirVoid) begin
                if (free[DirLeft])       got_l = DirLeft;
                else if (free[DirRight]) got_l = DirRight;
                else                     got_l = DirUp;
                free[got_l] = 1'b0;
            end
            if (pend_r && got_r == DirVoid) begin
                if (free[DirRight])      got_r = DirRight;
                else if (free[DirLeft])  got_r = DirLeft;
                else                     got_r = DirUp;
                free[got_r] = 1'b0;
            end
        end

        l_d = '0;
        r_d = '0;
        u_d = '0;
        case (got_l)
            DirLeft:  l_d = l_bus_i;
            DirRight: r_d = l_bus_i;
            DirUp:    u_d = l_bus_i;
            default:  ;
        endcase
        case (got_r)
            DirLeft:  l_d = r_bus_i;
            DirRight: r_d = r_bus_i;
            DirUp:    u_d = r_bus_i;
            default:  ;
        endcase
        case (got_u)
            DirLeft:  l_d = u_bus_i;
            DirRight: r_d = u_bus_i;
            DirUp:    u_d = u_bus_i;
            default:  ;
        endcase
        if (IsRoot) u_d = '0;

        defl_l = (want_l != DirVoid) && (got_l != want_l);
        defl_r = (want_r != DirVoid) && (got_r != want_r);
        defl_u = (want_u != DirVoid) && (got_u != want_u);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q     <= '0;
            r_q     <= '0;
            u_q     <= '0;
            rr_q    <= 1'b0;
            cnt_l_q <= '0;
            cnt_r_q <= '0;
            cnt_u_q <= '0;
        end else begin
            l_q  <= l_d;
            r_q  <= r_d;
            u_q  <= u_d;
            rr_q <= rr_d;
            if (stat_clr) begin
                cnt_l_q <= '0;
                cnt_r_q <= '0;
                cnt_u_q <= '0;
            end else begin
                if (defl_l && cnt_l_q != '1) cnt_l_q <= cnt_l_q + CNT_W'(1);
                if (defl_r && cnt_r_q != '1) cnt_r_q <= cnt_r_q + CNT_W'(1);
                if (defl_u && cnt_u_q != '1) cnt_u_q <= cnt_u_q + CNT_W'(1);
            end
        end
    end

    assign l_bus_o    = l_q;
    assign r_bus_o    = r_q;
    assign u_bus_o    = u_q;
    assign defl_cnt_l = cnt_l_q;
    assign defl_cnt_r = cnt_r_q;
    assign defl_cnt_u = cnt_u_q;

endmodule
